// File: rtl/rr_mux_arbiter_4x1_if.sv
// Bundle between four producers, the round-robin mux/arbiter and one consumer.
// master = producer/consumer side, slave = the arbiter itself.
interface rr_mux_arbiter_4x1_if #(
  parameter int BITS = 4
);
  logic [3:0]      req;
  logic [BITS-1:0] in0;
  logic [BITS-1:0] in1;
  logic [BITS-1:0] in2;
  logic [BITS-1:0] in3;
  logic            out_ready;
  logic [3:0]      gnt;
  logic [1:0]      sel;
  logic [BITS-1:0] out;
  logic            out_valid;

  modport master (
    output req, in0, in1, in2, in3, out_ready,
    input  gnt, sel, out, out_valid
  );

  modport slave (
    input  req, in0, in1, in2, in3, out_ready,
    output gnt, sel, out, out_valid
  );
endinterface

// File: rtl/rr_mux_arbiter_4x1.sv
// Round-robin 4:1 mux arbiter: picks one requester, registers its data and
// offers it downstream until accepted, then returns to IDLE for one cycle.
module rr_mux_arbiter_4x1 #(
  parameter int BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_mux_arbiter_4x1_if.slave  bus,
  output logic                 o_dbg_state,
  output logic [1:0]           o_dbg_ptr
);
  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // out/sel are stable while out_valid is high, and out_ready is ignored otherwise.
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_ptr, w_ptr_nxt;
  logic [BITS-1:0] r_out, w_out_nxt;
  logic [1:0]      r_sel, w_sel_nxt;
  logic [3:0]      r_gnt, w_gnt_nxt;
  logic            r_valid, w_valid_nxt;

  logic [7:0]      w_dbl;
  logic [3:0]      w_rot;
  logic [1:0]      w_off;
  logic [1:0]      w_winner;
  logic [BITS-1:0] w_mux;

  // Rotate req so bit 0 is the requester at ptr; the lowest set bit wins.
  assign w_dbl = {bus.req, bus.req} >> r_ptr;
  assign w_rot = w_dbl[3:0];

  always_comb begin
    w_off = 2'd3;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
  end

  assign w_winner = r_ptr + w_off;

  always_comb begin
    w_mux = bus.in0;
    case (w_winner)
      2'd0: w_mux = bus.in0;
      2'd1: w_mux = bus.in1;
      2'd2: w_mux = bus.in2;
      2'd3: w_mux = bus.in3;
      default: w_mux = bus.in0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_out_nxt   = r_out;
    w_sel_nxt   = r_sel;
    w_gnt_nxt   = 4'b0000;
    w_valid_nxt = r_valid;
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_out_nxt   = w_mux;
          w_sel_nxt   = w_winner;
          w_gnt_nxt   = 4'b0001 << w_winner;
          w_valid_nxt = 1'b1;
          w_ptr_nxt   = w_winner + 2'd1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_out   <= '0;
      r_sel   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_out   <= w_out_nxt;
      r_sel   <= w_sel_nxt;
      r_gnt   <= w_gnt_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign bus.out       = r_out;
  assign bus.sel       = r_sel;
  assign bus.gnt       = r_gnt;
  assign bus.out_valid = r_valid;
  assign o_dbg_state   = (r_state == HOLD);
  assign o_dbg_ptr     = r_ptr;
endmodule
